// File: rtl/alu_op_pkg.sv
// Shared ALU operation codes, RV32I opcode constants and the issued-entry type
// used by the ALU op decoder and the issue stage.
package alu_op_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_NE  = 4'b0100,
        OP_SLT = 4'b0101,
        OP_LUI = 4'b0110,
        OP_SRL = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_SLL = 4'b1001,
        OP_SRA = 4'b1010,
        OP_BLT = 4'b1100,
        OP_XOR = 4'b1110,
        OP_BGE = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e op;
        logic    jalr;
        logic    illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I opcode/funct3/funct7 to ALU operation table.
// Anything that does not decode yields AND with the illegal flag set.
module alu_op_decode
    import alu_op_pkg::*;
#(
    parameter int OPFIELD_WIDTH = 7
) (
    input  logic [OPFIELD_WIDTH-1:0] opcode,
    input  logic [2:0]               funct3,
    input  logic [OPFIELD_WIDTH-1:0] funct7,
    output alu_entry_t               entry
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic       legal;
    logic       jalr;
    alu_op_e    op;

    assign opc = 7'(opcode);
    assign f7  = 7'(funct7);

    always_comb begin
        legal = 1'b1;
        jalr  = 1'b0;
        op    = OP_ADD;
        case (opc)
            OPC_OP, OPC_OPIMM: begin
                // funct7 only selects between variants for 000 (register form) and 101
                case (funct3)
                    3'b000: begin
                        if (opc == OPC_OPIMM || f7 == F7_BASE) op = OP_ADD;
                        else if (f7 == F7_ALT)                  op = OP_SUB;
                        else                                    legal = 1'b0;
                    end
                    3'b111: op = OP_AND;
                    3'b110: op = OP_OR;
                    3'b100: op = OP_XOR;
                    3'b010: op = OP_SLT;
                    3'b001: op = OP_SLL;
                    3'b101: begin
                        if (f7 == F7_BASE)     op = OP_SRL;
                        else if (f7 == F7_ALT) op = OP_SRA;
                        else                   legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JAL: op = OP_ADD;
            OPC_LUI: op = OP_LUI;
            OPC_JALR: begin
                if (funct3 == 3'b000) jalr  = 1'b1;
                else                  legal = 1'b0;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_NE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        entry.op      = OP_AND;
        entry.jalr    = 1'b0;
        entry.illegal = 1'b1;
        if (legal) begin
            entry.op      = op;
            entry.jalr    = jalr;
            entry.illegal = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU op issue stage: decodes an offered instruction and holds it behind a
// valid/ready handshake. Define ALU_OP_ISSUE_SKID_EN for a registered-ready skid buffer.
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4,
    parameter int OPFIELD_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPFIELD_WIDTH-1:0] Opcode,
    input  logic [2:0]               Funct3,
    input  logic [OPFIELD_WIDTH-1:0] Funct7,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Jalr,
    output logic                     Illegal
);

    alu_entry_t dec_entry;
    alu_entry_t out_q, out_d;
    logic       out_valid_q, out_valid_d;

    alu_op_decode #(
        .OPFIELD_WIDTH(OPFIELD_WIDTH)
    ) u_decode (
        .opcode(Opcode),
        .funct3(Funct3),
        .funct7(Funct7),
        .entry (dec_entry)
    );

`ifdef ALU_OP_ISSUE_SKID_EN
    alu_entry_t skid_q, skid_d;
    logic       skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;

    // The skid entry only fills when the output register is stalled, so it
    // always drains into the output register before new input is taken.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid;
                if (in_valid) out_d = dec_entry;
            end
        end else if (in_valid && !skid_valid_q) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_ready) begin
            out_valid_d = in_valid;
            if (in_valid) out_d = dec_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign Operation = OPCODE_LENGTH'(out_q.op);
    assign Jalr      = out_q.jalr;
    assign Illegal   = out_q.illegal;

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
- REQ-001 SHALL have parameter OPCODE_LENGTH, default 4, width of the issued ALU operation code.
- REQ-002 SHALL have parameter OPFIELD_WIDTH, default 7, width of the instruction opcode and funct7 fields.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
- REQ-005 SHALL have port in_valid, input, 1, upstream offers a decoded instruction.
- REQ-006 SHALL have port in_ready, output, 1, block accepts the offer this cycle.
- REQ-007 SHALL have port Opcode, input, 7, instruction bits [6:0].
- REQ-008 SHALL have port Funct3, input, 3, instruction bits [14:12].
- REQ-009 SHALL have port Funct7, input, 7, instruction bits [31:25].
- REQ-010 SHALL have port flush, input, 1, discards all held and offered entries.
- REQ-011 SHALL have port out_valid, output, 1, Operation/Jalr/Illegal valid for the ALU.
- REQ-012 SHALL have port out_ready, input, 1, ALU stage consumes the entry.
- REQ-013 SHALL have port Operation, output, OPCODE_LENGTH, ALU operation code.
- REQ-014 SHALL have port Jalr, output, 1, entry is a JALR.
- REQ-015 SHALL have port Illegal, output, 1, entry did not decode.

Function
- REQ-016 SHALL accept an entry when in_valid && in_ready at a rising edge, and present it on out_valid no earlier than the next cycle (latency exactly 1 when empty).
- REQ-017 SHALL retire the head entry when out_valid && out_ready; outputs SHALL hold stable while out_valid && !out_ready.
- REQ-018 SHALL encode: AND 0000, OR 0001, ADD 0010, SUB 0011, NE 0100, SLT 0101, LUI 0110, SRL 0111, BEQ 1000, SLL 1001, SRA 1010, BLT 1100, XOR 1110, BGE 1111.
- REQ-019 SHALL decode Opcode 0110011: Funct3 000 -> ADD (Funct7 0000000) or SUB (Funct7 0100000); 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 -> SRL (Funct7 0000000) or SRA (Funct7 0100000); any other Funct7 Illegal.
- REQ-020 SHALL decode Opcode 0010011 as REQ-019 except Funct3 000 -> ADD regardless of Funct7; Funct3 011 Illegal.
- REQ-021 SHALL decode 0000011 and 0100011 -> ADD; 0110111 -> LUI; 1101111 -> ADD; 1100111 with Funct3 000 -> ADD with Jalr=1.
- REQ-022 SHALL decode 1100011: Funct3 000 BEQ, 001 NE, 100 BLT, 101 BGE; other Funct3 Illegal.
- REQ-023 SHALL, for any undecoded input, issue Operation 0000, Jalr 0, Illegal 1; Illegal entries SHALL flow through the handshake like legal ones.
- REQ-024 SHALL, when flush is high at an edge, empty all storage and drop any entry offered that cycle; out_valid SHALL be 0 the following cycle.
- REQ-025 SHALL, on simultaneous accept and retire while full-capable, keep occupancy unchanged and preserve order.

Reset
- REQ-026 SHALL on reset at an edge set out_valid 0, Operation 0000, Jalr 0, Illegal 0, storage empty; reset overrides flush and handshakes.
- REQ-027 SHALL drive in_ready 1 in the first cycle after reset deasserts.

Configuration
- REQ-028 SHALL, with ALU_OP_ISSUE_SKID_EN undefined, use one output register and in_ready = !out_valid || out_ready (combinational from out_ready).
- REQ-029 SHALL, with ALU_OP_ISSUE_SKID_EN defined, use a two-entry skid buffer with in_ready driven from a register (in_ready = skid entry empty), no combinational out_ready-to-in_ready path, full throughput preserved.

Structure
- REQ-030 SHALL place the operation-code enum (REQ-018) and RV32I opcode constants in package alu_op_pkg.
- REQ-031 SHALL place the combinational table of REQ-019..REQ-023 in sub-module alu_op_decode, instantiated once before the storage.

Verification
- REQ-032 SHALL check: Opcode 0110011, Funct3 000, Funct7 0100000, out_ready 1 -> next cycle out_valid 1, Operation 0011, Illegal 0.
- REQ-033 SHALL check: Opcode 1100111, Funct3 000 -> Operation 0010, Jalr 1; Opcode 1100011 Funct3 010 -> Operation 0000, Illegal 1.
- REQ-034 SHALL check: out_ready held 0 for 5 cycles with in_valid 1 -> outputs stable, in_ready 0 once full (1 entry base, 2 with skid), no entry lost or duplicated after release.
- REQ-035 SHALL check: flush with storage full and in_valid 1 -> next cycle out_valid 0, no flushed entry ever observed.
- REQ-036 SHALL check: reset asserted mid-stall -> next cycle out_valid 0, Operation 0000, in_ready 1 after release.
- REQ-037 SHALL check: back-to-back stream of 16 entries with out_ready 1 -> one retire per cycle, order preserved, in both macro settings.
